// File: rtl/gesture_match_engine.sv
// Nearest-template search: loads the test vector from SRAM, scores every enabled class
// by squared-Euclidean distance and reports the closest class with a threshold reject.
//
// state  | meaning
// IDLE   | waiting for i_start
// LOAD   | reading test vector points into the local register file
// SCAN   | streaming one class template through the distance accumulator
// CMP    | compare accumulator with best, pick next enabled class
// DONE   | o_valid strobe, result registers updated
module gesture_match_engine #(
    parameter  int NPTS        = 16,
    parameter  int COORD_W     = 8,
    parameter  int NCLASS      = 26,
    parameter  int ADDR_W      = 20,
    parameter  int CLASS_SHIFT = 10,
    parameter  int TEST_BASE   = 26 * 1024,
    localparam int DIST_W      = 2 * COORD_W + 2 + $clog2(NPTS)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [NCLASS-1:0]    i_class_en,
    input  logic [DIST_W-1:0]    i_threshold,
    output logic                 o_mem_req,
    output logic [ADDR_W-1:0]    o_mem_addr,
    input  logic                 i_mem_wait,
    input  logic [2*COORD_W-1:0] i_mem_rdata,
    output logic                 o_busy,
    output logic                 o_valid,
    output logic [4:0]           o_class,
    output logic [DIST_W-1:0]    o_dist,
    output logic                 o_reject
);
    localparam int PW = $clog2(NPTS);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_CMP, S_DONE} state_t;

    state_t               state;
    logic [PW-1:0]        pt;
    logic [4:0]           cls;
    logic [4:0]           best_cls;
    logic [NCLASS-1:0]    mask_q;
    logic [DIST_W-1:0]    thr_q;
    logic [DIST_W-1:0]    acc;
    logic [DIST_W-1:0]    best;
    logic [COORD_W-1:0]   test_x [NPTS];
    logic [COORD_W-1:0]   test_y [NPTS];

    logic                     rd_done;
    logic                     last_pt;
    logic [COORD_W-1:0]       lib_x;
    logic [COORD_W-1:0]       lib_y;
    logic signed [COORD_W:0]  dx;
    logic signed [COORD_W:0]  dy;
    logic signed [2*COORD_W+1:0] sq_x;
    logic signed [2*COORD_W+1:0] sq_y;
    logic [DIST_W-1:0]        term;
    logic                     nxt_found;
    logic [4:0]               nxt_cls;
    logic                     upd;
    logic [DIST_W-1:0]        cmp_best;
    logic [4:0]               cmp_cls;

    function automatic logic [ADDR_W-1:0] cls_base(input logic [4:0] c);
        return ADDR_W'(c) << CLASS_SHIFT;
    endfunction

    assign rd_done = o_mem_req && !i_mem_wait;
    assign last_pt = (pt == PW'(NPTS - 1));
    assign lib_x   = i_mem_rdata[2*COORD_W-1:COORD_W];
    assign lib_y   = i_mem_rdata[COORD_W-1:0];
    assign o_busy  = (state != S_IDLE);

    always_comb begin
        dx   = $signed({1'b0, lib_x}) - $signed({1'b0, test_x[pt]});
        dy   = $signed({1'b0, lib_y}) - $signed({1'b0, test_y[pt]});
        sq_x = dx * dx;
        sq_y = dy * dy;
        term = DIST_W'($unsigned(sq_x)) + DIST_W'($unsigned(sq_y));
    end

    // Lowest enabled class above the current one (any enabled class when leaving LOAD).
    always_comb begin
        nxt_found = 1'b0;
        nxt_cls   = '0;
        for (int i = NCLASS - 1; i >= 0; i--) begin
            if (mask_q[i] && (state != S_CMP || i > int'(cls))) begin
                nxt_found = 1'b1;
                nxt_cls   = 5'(i);
            end
        end
    end

    // Strict compare keeps the lower class index on ties since classes are visited ascending.
    always_comb begin
        upd      = (acc < best);
        cmp_best = upd ? acc : best;
        cmp_cls  = upd ? cls : best_cls;
    end

    always_ff @(posedge i_clk) begin
        if (state == S_LOAD && rd_done) begin
            test_x[pt] <= lib_x;
            test_y[pt] <= lib_y;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_IDLE;
            pt         <= '0;
            cls        <= '0;
            best_cls   <= '0;
            mask_q     <= '0;
            thr_q      <= '0;
            acc        <= '0;
            best       <= '0;
            o_mem_req  <= 1'b0;
            o_mem_addr <= '0;
            o_valid    <= 1'b0;
            o_class    <= '0;
            o_dist     <= '0;
            o_reject   <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (i_abort && state != S_IDLE && state != S_DONE) begin
                state     <= S_IDLE;
                o_mem_req <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (i_start && !i_abort) begin
                            mask_q     <= i_class_en;
                            thr_q      <= i_threshold;
                            best       <= '1;
                            best_cls   <= '0;
                            pt         <= '0;
                            o_mem_req  <= 1'b1;
                            o_mem_addr <= ADDR_W'(TEST_BASE);
                            state      <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        if (rd_done) begin
                            if (!last_pt) begin
                                pt         <= pt + PW'(1);
                                o_mem_addr <= o_mem_addr + ADDR_W'(1);
                            end else if (nxt_found) begin
                                pt         <= '0;
                                cls        <= nxt_cls;
                                acc        <= '0;
                                o_mem_addr <= cls_base(nxt_cls);
                                state      <= S_SCAN;
                            end else begin
                                o_mem_req <= 1'b0;
                                o_valid   <= 1'b1;
                                o_class   <= best_cls;
                                o_dist    <= best;
                                o_reject  <= 1'b1;
                                state     <= S_DONE;
                            end
                        end
                    end
                    S_SCAN: begin
                        if (rd_done) begin
                            acc <= acc + term;
                            if (last_pt) begin
                                o_mem_req <= 1'b0;
                                state     <= S_CMP;
                            end else begin
                                pt         <= pt + PW'(1);
                                o_mem_addr <= o_mem_addr + ADDR_W'(1);
                            end
                        end
                    end
                    S_CMP: begin
                        best     <= cmp_best;
                        best_cls <= cmp_cls;
                        if (nxt_found) begin
                            pt         <= '0;
                            cls        <= nxt_cls;
                            acc        <= '0;
                            o_mem_req  <= 1'b1;
                            o_mem_addr <= cls_base(nxt_cls);
                            state      <= S_SCAN;
                        end else begin
                            o_valid  <= 1'b1;
                            o_class  <= cmp_cls;
                            o_dist   <= cmp_best;
                            o_reject <= (cmp_best > thr_q);
                            state    <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state     <= S_IDLE;
                        o_mem_req <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_gesture_match_engine.sv
// Directed bench for gesture_match_engine (NPTS=16, NCLASS=4) with a combinational SRAM model.
module tb_gesture_match_engine;
    localparam int DW    = 22;
    localparam int TBASE = 26 * 1024;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic [3:0]    i_class_en = '0;
    logic [DW-1:0] i_threshold = '0;
    logic          o_mem_req;
    logic [19:0]   o_mem_addr;
    logic          i_mem_wait = 1'b0;
    logic [15:0]   i_mem_rdata;
    logic          o_busy;
    logic          o_valid;
    logic [4:0]    o_class;
    logic [DW-1:0] o_dist;
    logic          o_reject;

    int tests = 0;
    int fails = 0;
    int mode  = 0;

    logic [7:0] pv;
    logic [1:0] cv;

    gesture_match_engine #(
        .NPTS(16), .COORD_W(8), .NCLASS(4), .ADDR_W(20), .CLASS_SHIFT(10), .TEST_BASE(TBASE)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
        .i_class_en(i_class_en), .i_threshold(i_threshold),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .i_mem_wait(i_mem_wait),
        .i_mem_rdata(i_mem_rdata), .o_busy(o_busy), .o_valid(o_valid),
        .o_class(o_class), .o_dist(o_dist), .o_reject(o_reject)
    );

    always #5 i_clk = ~i_clk;

    // mode 0: test (10,10), class 2 (10,10), others (12,10)
    // mode 1: test (p,p), class0 (p+1,p), class1 (p,p), class2 (15-p,p), class3 (0,0)
    assign pv = {4'd0, o_mem_addr[3:0]};
    assign cv = o_mem_addr[11:10];
    always_comb begin
        i_mem_rdata = 16'h0000;
        if (o_mem_addr >= 20'(TBASE)) begin
            i_mem_rdata = (mode == 0) ? {8'd10, 8'd10} : {pv, pv};
        end else if (mode == 0) begin
            i_mem_rdata = (cv == 2'd2) ? {8'd10, 8'd10} : {8'd12, 8'd10};
        end else begin
            case (cv)
                2'd0:    i_mem_rdata = {pv + 8'd1, pv};
                2'd1:    i_mem_rdata = {pv, pv};
                2'd2:    i_mem_rdata = {8'd15 - pv, pv};
                default: i_mem_rdata = 16'h0000;
            endcase
        end
    end

    // Runs one search from a start pulse in cycle 0; vcyc = cycle of o_valid, -1 on timeout.
    task automatic run_op(input logic [3:0] mask, input logic [DW-1:0] thr, input bit rnd_wait,
                          input int bs_at, output int vcyc, output int reads, output int waits,
                          output int stab);
        logic        prev_hold;
        logic [19:0] prev_addr;
        vcyc = -1; reads = 0; waits = 0; stab = 0;
        prev_hold = 1'b0; prev_addr = '0;
        i_class_en = mask;
        i_threshold = thr;
        @(posedge i_clk); #1;
        i_start = 1'b1;
        i_mem_wait = 1'b0;
        for (int k = 1; k <= 1000 && vcyc < 0; k++) begin
            @(posedge i_clk); #1;
            if (k == bs_at) begin
                i_start = 1'b1;
                i_class_en = ~mask;
            end else begin
                i_start = 1'b0;
            end
            if (prev_hold && o_mem_addr !== prev_addr) stab++;
            i_mem_wait = rnd_wait ? 1'($urandom_range(0, 1)) : 1'b0;
            if (o_mem_req && !i_mem_wait) reads++;
            if (o_mem_req && i_mem_wait) waits++;
            prev_hold = o_mem_req && i_mem_wait;
            prev_addr = o_mem_addr;
            if (o_valid) vcyc = k;
        end
        i_start = 1'b0;
        i_mem_wait = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(posedge i_clk); #1;
        tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0d exp 0", o_busy); end
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0d exp 0", o_valid); end
        tests++; if (o_mem_req !== 1'b0) begin fails++; $display("FAIL reset_req got %0d exp 0", o_mem_req); end
        tests++; if (o_mem_addr !== 20'd0) begin fails++; $display("FAIL reset_addr got %0d exp 0", o_mem_addr); end
        tests++; if (o_class !== 5'd0) begin fails++; $display("FAIL reset_class got %0d exp 0", o_class); end
        tests++; if (o_dist !== '0) begin fails++; $display("FAIL reset_dist got %0d exp 0", o_dist); end
        tests++; if (o_reject !== 1'b0) begin fails++; $display("FAIL reset_reject got %0d exp 0", o_reject); end
    endtask

    task automatic test_all_enabled();
        int vc, rd, wt, st;
        mode = 0;
        run_op(4'b1111, DW'(100), 1'b0, 0, vc, rd, wt, st);
        tests++; if (vc !== 85) begin fails++; $display("FAIL all_valid_cycle got %0d exp 85", vc); end
        tests++; if (o_class !== 5'd2) begin fails++; $display("FAIL all_class got %0d exp 2", o_class); end
        tests++; if (o_dist !== DW'(0)) begin fails++; $display("FAIL all_dist got %0d exp 0", o_dist); end
        tests++; if (o_reject !== 1'b0) begin fails++; $display("FAIL all_reject got %0d exp 0", o_reject); end
        tests++; if (rd !== 80) begin fails++; $display("FAIL all_reads got %0d exp 80", rd); end
    endtask

    task automatic test_tie_lowest();
        int vc, rd, wt, st;
        mode = 0;
        // start pulse with a different mask mid-run must be ignored
        run_op(4'b1011, DW'(100), 1'b0, 10, vc, rd, wt, st);
        tests++; if (vc !== 68) begin fails++; $display("FAIL tie_valid_cycle got %0d exp 68", vc); end
        tests++; if (o_class !== 5'd0) begin fails++; $display("FAIL tie_class got %0d exp 0", o_class); end
        tests++; if (o_dist !== DW'(64)) begin fails++; $display("FAIL tie_dist got %0d exp 64", o_dist); end
        tests++; if (o_reject !== 1'b0) begin fails++; $display("FAIL tie_reject got %0d exp 0", o_reject); end
    endtask

    task automatic test_threshold();
        int vc, rd, wt, st;
        mode = 0;
        run_op(4'b1011, DW'(63), 1'b0, 0, vc, rd, wt, st);
        tests++; if (o_class !== 5'd0) begin fails++; $display("FAIL thr_class got %0d exp 0", o_class); end
        tests++; if (o_dist !== DW'(64)) begin fails++; $display("FAIL thr_dist got %0d exp 64", o_dist); end
        tests++; if (o_reject !== 1'b1) begin fails++; $display("FAIL thr_reject got %0d exp 1", o_reject); end
    endtask

    task automatic test_abort();
        int nvalid = 0;
        mode = 0;
        i_class_en = 4'b1111;
        i_threshold = DW'(100);
        @(posedge i_clk); #1;
        i_start = 1'b1;
        for (int k = 1; k <= 120; k++) begin
            @(posedge i_clk); #1;
            i_start = 1'b0;
            if (o_valid) nvalid++;
            if (k == 30) i_abort = 1'b1;
            if (k == 31) begin
                i_abort = 1'b0;
                tests++; if (o_mem_req !== 1'b0) begin fails++; $display("FAIL abort_req got %0d exp 0", o_mem_req); end
                tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %0d exp 0", o_busy); end
            end
        end
        tests++; if (nvalid !== 0) begin fails++; $display("FAIL abort_no_valid got %0d exp 0", nvalid); end
        tests++; if (o_class !== 5'd0) begin fails++; $display("FAIL abort_class_held got %0d exp 0", o_class); end
        tests++; if (o_dist !== DW'(64)) begin fails++; $display("FAIL abort_dist_held got %0d exp 64", o_dist); end
        tests++; if (o_reject !== 1'b1) begin fails++; $display("FAIL abort_reject_held got %0d exp 1", o_reject); end
        i_start = 1'b1;
        i_abort = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        i_abort = 1'b0;
        tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL start_abort_idle got busy %0d exp 0", o_busy); end
    endtask

    task automatic test_mask_zero();
        int vc, rd, wt, st;
        mode = 0;
        run_op(4'b0000, DW'(100), 1'b0, 0, vc, rd, wt, st);
        tests++; if (vc !== 17) begin fails++; $display("FAIL zero_valid_cycle got %0d exp 17", vc); end
        tests++; if (o_reject !== 1'b1) begin fails++; $display("FAIL zero_reject got %0d exp 1", o_reject); end
        tests++; if (o_class !== 5'd0) begin fails++; $display("FAIL zero_class got %0d exp 0", o_class); end
        tests++; if (o_dist !== {DW{1'b1}}) begin fails++; $display("FAIL zero_dist got %0h exp 3fffff", o_dist); end
        tests++; if (rd !== 16) begin fails++; $display("FAIL zero_reads got %0d exp 16", rd); end
    endtask

    task automatic test_varied();
        int vc, rd, wt, st;
        mode = 1;
        run_op(4'b1101, DW'(16), 1'b0, 0, vc, rd, wt, st);
        tests++; if (vc !== 68) begin fails++; $display("FAIL var1_valid_cycle got %0d exp 68", vc); end
        tests++; if (o_class !== 5'd0) begin fails++; $display("FAIL var1_class got %0d exp 0", o_class); end
        tests++; if (o_dist !== DW'(16)) begin fails++; $display("FAIL var1_dist got %0d exp 16", o_dist); end
        tests++; if (o_reject !== 1'b0) begin fails++; $display("FAIL var1_reject got %0d exp 0", o_reject); end
        run_op(4'b1100, DW'(1359), 1'b0, 0, vc, rd, wt, st);
        tests++; if (vc !== 51) begin fails++; $display("FAIL var2_valid_cycle got %0d exp 51", vc); end
        tests++; if (o_class !== 5'd2) begin fails++; $display("FAIL var2_class got %0d exp 2", o_class); end
        tests++; if (o_dist !== DW'(1360)) begin fails++; $display("FAIL var2_dist got %0d exp 1360", o_dist); end
        tests++; if (o_reject !== 1'b1) begin fails++; $display("FAIL var2_reject got %0d exp 1", o_reject); end
        mode = 0;
    endtask

    task automatic test_random_wait();
        int vc, rd, wt, st;
        mode = 0;
        run_op(4'b1111, DW'(100), 1'b1, 0, vc, rd, wt, st);
        tests++; if (vc !== 85 + wt) begin fails++; $display("FAIL wait_valid_cycle got %0d exp %0d", vc, 85 + wt); end
        tests++; if (o_class !== 5'd2) begin fails++; $display("FAIL wait_class got %0d exp 2", o_class); end
        tests++; if (o_dist !== DW'(0)) begin fails++; $display("FAIL wait_dist got %0d exp 0", o_dist); end
        tests++; if (o_reject !== 1'b0) begin fails++; $display("FAIL wait_reject got %0d exp 0", o_reject); end
        tests++; if (rd !== 80) begin fails++; $display("FAIL wait_reads got %0d exp 80", rd); end
        tests++; if (st !== 0) begin fails++; $display("FAIL wait_addr_stable got %0d changes exp 0", st); end
    endtask

    task automatic test_back_to_back();
        int vc, rd, wt, st;
        mode = 0;
        run_op(4'b1011, DW'(63), 1'b0, 0, vc, rd, wt, st);
        tests++; if (o_busy !== 1'b1) begin fails++; $display("FAIL b2b_busy_at_valid got %0d exp 1", o_busy); end
        run_op(4'b1111, DW'(100), 1'b0, 0, vc, rd, wt, st);
        tests++; if (vc !== 85) begin fails++; $display("FAIL b2b_valid_cycle got %0d exp 85", vc); end
        tests++; if (o_class !== 5'd2) begin fails++; $display("FAIL b2b_class got %0d exp 2", o_class); end
    endtask

    task automatic test_reset_mid_scan();
        int vc, rd, wt, st;
        mode = 0;
        i_class_en = 4'b1111;
        i_threshold = DW'(100);
        @(posedge i_clk); #1;
        i_start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge i_clk); #1;
            i_start = 1'b0;
        end
        i_rst = 1'b1;
        #1;
        tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %0d exp 0", o_busy); end
        tests++; if (o_mem_req !== 1'b0) begin fails++; $display("FAIL rst_req got %0d exp 0", o_mem_req); end
        tests++; if (o_mem_addr !== 20'd0) begin fails++; $display("FAIL rst_addr got %0d exp 0", o_mem_addr); end
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %0d exp 0", o_valid); end
        tests++; if (o_class !== 5'd0) begin fails++; $display("FAIL rst_class got %0d exp 0", o_class); end
        tests++; if (o_dist !== '0) begin fails++; $display("FAIL rst_dist got %0d exp 0", o_dist); end
        tests++; if (o_reject !== 1'b0) begin fails++; $display("FAIL rst_reject got %0d exp 0", o_reject); end
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        run_op(4'b1111, DW'(100), 1'b0, 0, vc, rd, wt, st);
        tests++; if (vc !== 85) begin fails++; $display("FAIL post_rst_valid_cycle got %0d exp 85", vc); end
        tests++; if (o_class !== 5'd2) begin fails++; $display("FAIL post_rst_class got %0d exp 2", o_class); end
        tests++; if (o_dist !== DW'(0)) begin fails++; $display("FAIL post_rst_dist got %0d exp 0", o_dist); end
    endtask

    initial begin
        test_reset();
        test_all_enabled();
        test_tie_lowest();
        test_threshold();
        test_abort();
        test_mask_zero();
        test_varied();
        test_random_wait();
        test_back_to_back();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
